// File: rtl/execute_reg.sv
// execute_reg -- Y86-64 style execute-stage pipeline register plus the
// condition-code register.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   E_bubble_i, E_stall_i   pipeline control (bubble wins over stall)
//   d_*_i                   decode-stage fields to be latched into E
//   E_*_o                   registered execute-stage fields
//   set_cc_i, e_zf/sf/of_i  condition-code update request and ALU flags
//   m_stat_i, W_stat_i      downstream status; an exception there blocks CC update
//   cc_o                    registered {ZF,SF,OF}
//   bubble_cnt_o, stall_cnt_o, cc_upd_cnt_o
//                           saturating performance counters, present only
//                           when PIPE_PERF_CNT_EN is defined
module execute_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        E_bubble_i,
  input  logic        E_stall_i,
  input  logic [2:0]  d_stat_i,
  input  logic [3:0]  d_icode_i,
  input  logic [3:0]  d_ifun_i,
  input  logic [63:0] d_valC_i,
  input  logic [63:0] d_valA_i,
  input  logic [63:0] d_valB_i,
  input  logic [3:0]  d_dstE_i,
  input  logic [3:0]  d_dstM_i,
  input  logic [3:0]  d_srcA_i,
  input  logic [3:0]  d_srcB_i,
  output logic [2:0]  E_stat_o,
  output logic [3:0]  E_icode_o,
  output logic [3:0]  E_ifun_o,
  output logic [63:0] E_valC_o,
  output logic [63:0] E_valA_o,
  output logic [63:0] E_valB_o,
  output logic [3:0]  E_dstE_o,
  output logic [3:0]  E_dstM_o,
  output logic [3:0]  E_srcA_o,
  output logic [3:0]  E_srcB_o,
  input  logic        set_cc_i,
  input  logic        e_zf_i,
  input  logic        e_sf_i,
  input  logic        e_of_i,
  input  logic [2:0]  m_stat_i,
  input  logic [2:0]  W_stat_i,
  output logic [2:0]  cc_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] cc_upd_cnt_o
`endif
);

  localparam logic [2:0] SAOK   = 3'h1;
  localparam logic [2:0] SHLT   = 3'h2;
  localparam logic [2:0] SADR   = 3'h3;
  localparam logic [2:0] SINS   = 3'h4;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [2:0] CC_RST = 3'b100;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat: SAOK, icode: NOP, ifun: 4'h0,
    valC: 64'h0, valA: 64'h0, valB: 64'h0,
    dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
  };

  e_reg_t e_q;
  e_reg_t d_in;
  logic   cc_upd;

  assign d_in = '{
    stat: d_stat_i, icode: d_icode_i, ifun: d_ifun_i,
    valC: d_valC_i, valA: d_valA_i, valB: d_valB_i,
    dstE: d_dstE_i, dstM: d_dstM_i, srcA: d_srcA_i, srcB: d_srcB_i
  };

  // Reset and bubble both inject a NOP; stall only holds when no bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || E_bubble_i) e_q <= E_BUBBLE;
    else if (!E_stall_i)     e_q <= d_in;
  end

  // Qualification looks at the instruction already sitting in E (e_q),
  // not the one arriving from decode. An exception further down the pipe
  // must not let a younger instruction change the flags.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

  assign cc_upd = set_cc_i && (e_q.icode == OPQ) &&
                  !is_exc(m_stat_i) && !is_exc(W_stat_i);

  always_ff @(posedge clk_i) begin
    if (rst_i)       cc_o <= CC_RST;
    else if (cc_upd) cc_o <= {e_zf_i, e_sf_i, e_of_i};
  end

  assign E_stat_o  = e_q.stat;
  assign E_icode_o = e_q.icode;
  assign E_ifun_o  = e_q.ifun;
  assign E_valC_o  = e_q.valC;
  assign E_valA_o  = e_q.valA;
  assign E_valB_o  = e_q.valB;
  assign E_dstE_o  = e_q.dstE;
  assign E_dstM_o  = e_q.dstM;
  assign E_srcA_o  = e_q.srcA;
  assign E_srcB_o  = e_q.srcB;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
      cc_upd_cnt_o <= '0;
    end else begin
      if (E_bubble_i && bubble_cnt_o != CNT_MAX)
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      if (E_stall_i && !E_bubble_i && stall_cnt_o != CNT_MAX)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (cc_upd && cc_upd_cnt_o != CNT_MAX)
        cc_upd_cnt_o <= cc_upd_cnt_o + 32'd1;
    end
  end
`endif

endmodule
